// File: rtl/sram_arbiter_2port_if.sv
// Requester-side bundle for sram_arbiter_2port: one instance per requester.
// The master drives a request and sees its ack and read return.
interface sram_arbiter_2port_if;
    logic        req;
    logic        read_not_write;
    logic [13:0] address;
    logic [31:0] write_data;
    logic [3:0]  byte_enable;
    logic        ack;
    logic        read_data_valid;
    logic [31:0] read_data;

    modport master (
        output req, read_not_write, address, write_data, byte_enable,
        input  ack, read_data_valid, read_data
    );

    modport slave (
        input  req, read_not_write, address, write_data, byte_enable,
        output ack, read_data_valid, read_data
    );
endinterface

// File: rtl/sram_arbiter_2port.sv
// Fixed-priority (A over B) arbiter with a B starvation limit in front of a
// 16384x32 byte-write SRAM; read data returns one enabled cycle after the grant.
module sram_arbiter_2port #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 sram_clock,
    input  logic                 reset,
    input  logic                 sram_clock__enable,
    sram_arbiter_2port_if.slave  a,
    sram_arbiter_2port_if.slave  b,
    output logic                 sram_select,
    output logic                 sram_read_not_write,
    output logic [13:0]          sram_address,
    output logic [31:0]          sram_write_data,
    output logic [3:0]           sram_write_enable,
    input  logic [31:0]          sram_data_out
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        RET_NONE = 2'd0,
        RET_A    = 2'd1,
        RET_B    = 2'd2
    } ret_e;

    ret_e       ret_q, ret_d;
    logic [3:0] starve_q, starve_d;
    logic       active;
    logic       grant_a;
    logic       grant_b;

    always_ff @(posedge sram_clock) begin
        if (reset) begin
            ret_q    <= RET_NONE;
            starve_q <= '0;
        end else begin
            ret_q    <= ret_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        active  = sram_clock__enable & ~reset;
        grant_b = active & b.req & ((starve_q >= LIMIT) | ~a.req);
        grant_a = active & a.req & ~grant_b;
        a.ack   = grant_a;
        b.ack   = grant_b;
    end

    always_comb begin
        sram_select         = grant_a | grant_b;
        sram_read_not_write = 1'b0;
        sram_address        = '0;
        sram_write_data     = '0;
        sram_write_enable   = '0;
        if (grant_a) begin
            sram_read_not_write = a.read_not_write;
            sram_address        = a.address;
            sram_write_data     = a.write_data;
            sram_write_enable   = a.read_not_write ? 4'b0000 : a.byte_enable;
        end else if (grant_b) begin
            sram_read_not_write = b.read_not_write;
            sram_address        = b.address;
            sram_write_data     = b.write_data;
            sram_write_enable   = b.read_not_write ? 4'b0000 : b.byte_enable;
        end
    end

    // Counter and return tag advance only on enabled cycles, so a stalled
    // read is still delivered on the next enabled cycle.
    always_comb begin
        starve_d = starve_q;
        ret_d    = ret_q;
        if (sram_clock__enable) begin
            if (grant_b || !b.req) begin
                starve_d = '0;
            end else if (starve_q != 4'hF) begin
                starve_d = starve_q + 4'd1;
            end
            if (grant_a && a.read_not_write) begin
                ret_d = RET_A;
            end else if (grant_b && b.read_not_write) begin
                ret_d = RET_B;
            end else begin
                ret_d = RET_NONE;
            end
        end
    end

    always_comb begin
        a.read_data_valid = active & (ret_q == RET_A);
        b.read_data_valid = active & (ret_q == RET_B);
        a.read_data       = a.read_data_valid ? sram_data_out : '0;
        b.read_data       = b.read_data_valid ? sram_data_out : '0;
    end

endmodule

// File: tb/tb_sram_arbiter_2port.sv
// Randomized and directed bench for sram_arbiter_2port against a behavioural
// model of the arbitration rules, with a behavioural SRAM on the memory side.
module tb_sram_arbiter_2port;

    localparam int LIMIT = 4;

    logic        sram_clock;
    logic        reset;
    logic        sram_clock__enable;
    logic        sram_select;
    logic        sram_read_not_write;
    logic [13:0] sram_address;
    logic [31:0] sram_write_data;
    logic [3:0]  sram_write_enable;
    logic [31:0] sram_data_out;

    sram_arbiter_2port_if a_if ();
    sram_arbiter_2port_if b_if ();

    sram_arbiter_2port #(.STARVE_LIMIT(LIMIT)) dut (
        .sram_clock          (sram_clock),
        .reset               (reset),
        .sram_clock__enable  (sram_clock__enable),
        .a                   (a_if),
        .b                   (b_if),
        .sram_select         (sram_select),
        .sram_read_not_write (sram_read_not_write),
        .sram_address        (sram_address),
        .sram_write_data     (sram_write_data),
        .sram_write_enable   (sram_write_enable),
        .sram_data_out       (sram_data_out)
    );

    initial sram_clock = 1'b0;
    always #5 sram_clock = ~sram_clock;

    // Behavioural SRAM: output register only updates on an enabled read.
    logic [31:0] mem_env [16384];
    always @(posedge sram_clock) begin
        if (sram_clock__enable && sram_select) begin
            if (sram_read_not_write) begin
                sram_data_out <= mem_env[sram_address];
            end else begin
                for (int i = 0; i < 4; i++)
                    if (sram_write_enable[i]) mem_env[sram_address][8*i +: 8] = sram_write_data[8*i +: 8];
            end
        end
    end

    // Reference model state
    logic [31:0] mem_ref [16384];
    int          starve_m;
    int          owner_m;      // 0 none, 1 A, 2 B: who gets the next return
    logic [31:0] ret_data_m;
    bit          model_live;

    int n_vec;
    int n_err;

    logic        obs_a_ack, obs_b_ack, obs_a_valid, obs_b_valid;
    logic [31:0] obs_a_data, obs_b_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_a(input logic req, input logic rnw, input logic [13:0] addr,
                           input logic [31:0] wd, input logic [3:0] be);
        a_if.req = req; a_if.read_not_write = rnw; a_if.address = addr;
        a_if.write_data = wd; a_if.byte_enable = be;
    endtask

    task automatic drive_b(input logic req, input logic rnw, input logic [13:0] addr,
                           input logic [31:0] wd, input logic [3:0] be);
        b_if.req = req; b_if.read_not_write = rnw; b_if.address = addr;
        b_if.write_data = wd; b_if.byte_enable = be;
    endtask

    task automatic write_ref(input logic [13:0] addr, input logic [31:0] wd, input logic [3:0] be);
        for (int i = 0; i < 4; i++)
            if (be[i]) mem_ref[addr][8*i +: 8] = wd[8*i +: 8];
    endtask

    // One clock cycle: apply reset/enable, check every output against the
    // model, then advance the model across the rising edge.
    task automatic step(input logic rst_v, input logic en_v);
        bit          act, ga, gb, rd_a, rd_b;
        logic [31:0] e_wd;
        logic [13:0] e_addr;
        logic        e_rnw;
        logic [3:0]  e_we;
        reset = rst_v;
        sram_clock__enable = en_v;
        #1;
        act = en_v && !rst_v;
        gb  = act && b_if.req && (starve_m >= LIMIT || !a_if.req);
        ga  = act && a_if.req && !gb;
        rd_a = act && model_live && owner_m == 1;
        rd_b = act && model_live && owner_m == 2;
        e_rnw = 1'b0; e_addr = '0; e_wd = '0; e_we = '0;
        if (ga) begin
            e_rnw = a_if.read_not_write; e_addr = a_if.address; e_wd = a_if.write_data;
            e_we = e_rnw ? 4'b0 : a_if.byte_enable;
        end else if (gb) begin
            e_rnw = b_if.read_not_write; e_addr = b_if.address; e_wd = b_if.write_data;
            e_we = e_rnw ? 4'b0 : b_if.byte_enable;
        end
        check("a_ack", 32'(a_if.ack), 32'(ga));
        check("b_ack", 32'(b_if.ack), 32'(gb));
        check("sram_select", 32'(sram_select), 32'(ga || gb));
        check("sram_rnw", 32'(sram_read_not_write), 32'(e_rnw));
        check("sram_address", 32'(sram_address), 32'(e_addr));
        check("sram_write_data", sram_write_data, e_wd);
        check("sram_we", 32'(sram_write_enable), 32'(e_we));
        check("a_valid", 32'(a_if.read_data_valid), 32'(rd_a));
        check("b_valid", 32'(b_if.read_data_valid), 32'(rd_b));
        check("a_rdata", a_if.read_data, rd_a ? ret_data_m : 32'h0);
        check("b_rdata", b_if.read_data, rd_b ? ret_data_m : 32'h0);
        if (model_live) check("starve_count", 32'(dut.starve_q), 32'(starve_m));
        obs_a_ack = a_if.ack; obs_b_ack = b_if.ack;
        obs_a_valid = a_if.read_data_valid; obs_b_valid = b_if.read_data_valid;
        obs_a_data = a_if.read_data; obs_b_data = b_if.read_data;
        @(posedge sram_clock);
        if (rst_v) begin
            starve_m = 0; owner_m = 0; model_live = 1'b1;
        end else if (en_v) begin
            if (gb || !b_if.req) starve_m = 0;
            else if (starve_m < 15) starve_m++;
            owner_m = 0;
            if ((ga || gb) && e_rnw) begin
                owner_m = ga ? 1 : 2;
                ret_data_m = mem_ref[e_addr];
            end
            if ((ga || gb) && !e_rnw) write_ref(e_addr, e_wd, e_we);
        end
        @(negedge sram_clock);
    endtask

    task automatic rand_a();
        drive_a(($urandom_range(0, 9) < 7), 1'($urandom), 14'($urandom_range(0, 7)),
                $urandom, 4'($urandom));
    endtask

    task automatic rand_b();
        drive_b(($urandom_range(0, 9) < 7), 1'($urandom), 14'($urandom_range(0, 7)),
                $urandom, 4'($urandom));
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        starve_m = 0; owner_m = 0; ret_data_m = '0; model_live = 1'b0;
        sram_data_out = '0;
        for (int i = 0; i < 16384; i++) begin
            mem_env[i] = $urandom;
            mem_ref[i] = mem_env[i];
        end
        reset = 1'b1; sram_clock__enable = 1'b1;
        drive_a(1'b1, 1'b1, 14'h0, '0, 4'h0);
        drive_b(1'b1, 1'b1, 14'h0, '0, 4'h0);
        @(negedge sram_clock);

        // Reset held with both requesting, then A wins first
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            check("reset_a_ack", 32'(obs_a_ack), 32'h0);
        end
        step(1'b0, 1'b1);
        check("post_reset_a_ack", 32'(obs_a_ack), 32'h1);
        drive_a(1'b0, 1'b0, '0, '0, '0);
        drive_b(1'b0, 1'b0, '0, '0, '0);
        step(1'b0, 1'b1);

        // Full write, read back, then byte-enable merge
        drive_a(1'b1, 1'b0, 14'h1234, 32'hDEADBEEF, 4'b1111); step(1'b0, 1'b1);
        drive_a(1'b1, 1'b1, 14'h1234, '0, 4'b0000);           step(1'b0, 1'b1);
        drive_a(1'b0, 1'b0, '0, '0, '0);                      step(1'b0, 1'b1);
        check("wr_rd_valid", 32'(obs_a_valid), 32'h1);
        check("wr_rd_data", obs_a_data, 32'hDEADBEEF);
        check("wr_rd_b_valid", 32'(obs_b_valid), 32'h0);
        drive_a(1'b1, 1'b0, 14'h1234, 32'h11223344, 4'b0101); step(1'b0, 1'b1);
        drive_a(1'b1, 1'b1, 14'h1234, '0, 4'b0000);           step(1'b0, 1'b1);
        drive_a(1'b0, 1'b0, '0, '0, '0);                      step(1'b0, 1'b1);
        check("byte_en_data", obs_a_data, 32'hDE22BE44);

        // Starvation: both held, B forced every fifth cycle
        drive_a(1'b1, 1'b1, 14'h0003, '0, '0);
        drive_b(1'b1, 1'b1, 14'h0004, '0, '0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1);
            check("starve_pattern_b", 32'(obs_b_ack), 32'(i % 5 == 4));
        end
        drive_a(1'b0, 1'b0, '0, '0, '0);
        drive_b(1'b0, 1'b0, '0, '0, '0);
        step(1'b0, 1'b1);

        // Clock-enable stall across a pending read
        drive_a(1'b1, 1'b0, 14'h0010, 32'h5A5A5A5A, 4'b1111); step(1'b0, 1'b1);
        drive_a(1'b1, 1'b1, 14'h0010, '0, '0);                step(1'b0, 1'b1);
        drive_a(1'b1, 1'b1, 14'h0020, '0, '0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            check("stall_no_grant", 32'(obs_a_ack), 32'h0);
            check("stall_no_valid", 32'(obs_a_valid), 32'h0);
        end
        drive_a(1'b0, 1'b0, '0, '0, '0);
        step(1'b0, 1'b1);
        check("stall_return_valid", 32'(obs_a_valid), 32'h1);
        check("stall_return_data", obs_a_data, 32'h5A5A5A5A);

        // Alternating A/B reads, then reset discards a B read in flight
        drive_a(1'b1, 1'b1, 14'h0001, '0, '0); step(1'b0, 1'b1);
        drive_a(1'b0, 1'b0, '0, '0, '0);
        drive_b(1'b1, 1'b1, 14'h0002, '0, '0); step(1'b0, 1'b1);
        check("alt_a_valid", 32'(obs_a_valid), 32'h1);
        check("alt_a_data", obs_a_data, mem_env[1]);
        drive_b(1'b0, 1'b0, '0, '0, '0);       step(1'b0, 1'b1);
        check("alt_b_valid", 32'(obs_b_valid), 32'h1);
        check("alt_b_data", obs_b_data, mem_env[2]);
        drive_b(1'b1, 1'b1, 14'h0002, '0, '0); step(1'b0, 1'b1);
        drive_b(1'b0, 1'b0, '0, '0, '0);       step(1'b1, 1'b1);
        check("reset_drop_b_valid0", 32'(obs_b_valid), 32'h0);
        step(1'b0, 1'b1);
        check("reset_drop_b_valid1", 32'(obs_b_valid), 32'h0);

        // Random traffic; each requester holds its fields until acked
        rand_a(); rand_b();
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 85));
            if (!a_if.req || obs_a_ack) rand_a();
            if (!b_if.req || obs_b_ack) rand_b();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_arbiter_2port.md
# sram_arbiter_2port

Two-requester arbiter and sequencer for the 16384x32 byte-write-enable single-port SRAM (`bram__se_sram_srw_16384x32_we8`). It shares the SRAM port between requester A (high priority, e.g. CPU) and requester B (low priority, e.g. DMA) using fixed priority with a starvation limit. It drives the SRAM select, address, data and byte enables, and returns read data one cycle later to whichever requester issued the read. It sits directly in front of the SRAM instance, inside the same `sram_clock` domain.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive cycles B may be refused while requesting before it is forced a grant; legal range 1..15.

Ports:
- `sram_clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sram_clock__enable`  in  1  global advance; when low, no grant, all state held.
- `a_req`  in  1  A requests an access this cycle.
- `a_read_not_write`  in  1  1 = read, 0 = write.
- `a_address`  in  14  word address.
- `a_write_data`  in  32  write data.
- `a_byte_enable`  in  4  bit i writes byte i.
- `a_ack`  out  1  A request accepted this cycle.
- `a_read_data_valid`  out  1  `a_read_data` carries A's read result.
- `a_read_data`  out  32  read result; 0 when not valid.
- `b_*`: seven ports identical to the `a_*` set above, for requester B.
- `sram_select`  out  1  SRAM access this cycle.
- `sram_read_not_write`  out  1  to SRAM.
- `sram_address`  out  14  to SRAM.
- `sram_write_data`  out  32  to SRAM.
- `sram_write_enable`  out  4  byte enables to SRAM.
- `sram_data_out`  in  32  SRAM read data, valid one enabled cycle after the read.

## Operation
- **State registers:**
  - `starve_count[3:0]`
  - `pending_a`, `pending_b`: read-return tags.
- **Grant decision** (combinational, only when `sram_clock__enable` = 1 and `reset` = 0):
  - Force B: `b_req` and `starve_count >= STARVE_LIMIT` → grant B.
  - Otherwise: `a_req` → grant A; else `b_req` → grant B; else no grant.
- **Ack:** `a_ack`/`b_ack` equal the grant, combinationally in the same cycle. A requester holds its request fields stable until ack; unacked requests carry no state.
- **SRAM drive:**
  - `sram_select` = any grant.
  - The address, data, read_not_write and byte_enable of the granted requester are muxed to the `sram_*` outputs.
  - With no grant, all `sram_*` outputs are 0.
  - `sram_write_enable` is forced to 0000 on reads.
- **Starvation counter** (updates on enabled cycles only):
  - B granted, or `b_req` = 0 → 0.
  - `b_req` = 1 and B refused → +1, saturating at 15.
- **Read return:**
  - On an enabled cycle, `pending_a` <= (A granted read) and `pending_b` <= (B granted read).
  - `x_read_data_valid` = `pending_x & sram_clock__enable`.
  - `x_read_data` = `sram_data_out` when valid, else 0.
  - At most one pending flag is set at a time.
- **Writes** with byte_enable 0000 are granted and acked but modify nothing.
- **`sram_clock__enable` low:**
  - No ack, `sram_select` = 0, valids 0.
  - Pending flags and counter hold, so the return is delivered on the next enabled cycle. The SRAM output holds because it is not clocked.
- **Reset (synchronous):**
  - Counter 0, pending flags 0.
  - While `reset` = 1: all acks 0, `sram_select` 0, valids 0, all `sram_*` and read-data outputs 0.
  - A read granted in the cycle before reset asserts is discarded and never returned.

## Timing
- Grant, ack and SRAM drive occur in the same cycle as the request (zero-cycle arbitration).
- Read latency is 1 enabled cycle: data is presented to the requester in the enabled cycle following the grant.
- Back-to-back reads are supported every cycle, including reads alternating between A and B; each result is tagged to the requester granted in the preceding enabled cycle.
- Worst-case B wait with continuous A traffic is `STARVE_LIMIT` refused cycles, granted on cycle `STARVE_LIMIT+1`. A then waits exactly one cycle.
- A read to an address written in the previous cycle returns the new data (sequential port, no collision).

## Test plan
- **Reset:** hold `reset` 3 cycles with `a_req`=`b_req`=1 → all acks 0, `sram_select` 0, valids 0. After release, A is acked on the first cycle.
- **Write then read:** A writes 0xDEADBEEF to 0x1234 with byte_enable 1111, then reads 0x1234 → `a_ack` each cycle; `a_read_data_valid`=1 one cycle after the read with data 0xDEADBEEF; `b_read_data_valid` stays 0.
- **Byte-enable write:** A writes 0x11223344 with byte_enable 0101 over 0xDEADBEEF → a subsequent read returns 0xDE22BE44.
- **Starvation:** `a_req` held 1, `b_req` held 1, `STARVE_LIMIT`=4 → grant pattern A,A,A,A,B repeating. `starve_count` reaches 4, then returns to 0 on the B grant.
- **Clock-enable stall:** A reads 0x0010 (holding 0x5A5A5A5A), then `sram_clock__enable`=0 for 3 cycles → no valid during the stall, `a_read_data_valid`=1 with 0x5A5A5A5A on the first re-enabled cycle, and no new grant while stalled.
- **Alternating reads + mid-read reset:** A reads 0x0001 then B reads 0x0002 on consecutive cycles → each valid goes to the correct requester on consecutive cycles. Asserting `reset` in the cycle after a B read grant → `b_read_data_valid` never asserts.
